// File: rtl/csr_mtrap_unit_pkg.sv
// rtl/csr_mtrap_unit_pkg.sv - CSR addresses, cause codes, op encodings and FSM states
package csr_mtrap_unit_pkg;

    localparam logic [11:0] CSR_MSTATUS       = 12'h300;
    localparam logic [11:0] CSR_MIE           = 12'h304;
    localparam logic [11:0] CSR_MTVEC         = 12'h305;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
    localparam logic [11:0] CSR_MEPC          = 12'h341;
    localparam logic [11:0] CSR_MCAUSE        = 12'h342;
    localparam logic [11:0] CSR_MTVAL         = 12'h343;
    localparam logic [11:0] CSR_MIP           = 12'h344;
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] CSR_MVENDORID     = 12'hF11;
    localparam logic [11:0] CSR_MARCHID       = 12'hF12;
    localparam logic [11:0] CSR_MIMPID        = 12'hF13;
    localparam logic [11:0] CSR_MHARTID       = 12'hF14;

    localparam logic [3:0] IRQ_MSI = 4'd3;
    localparam logic [3:0] IRQ_MTI = 4'd7;
    localparam logic [3:0] IRQ_MEI = 4'd11;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } trap_state_e;

    // pend = {external, software, timer}; external beats software beats timer
    function automatic logic [3:0] irq_prio(input logic [2:0] pend);
        if (pend[2]) begin
            return IRQ_MEI;
        end else if (pend[1]) begin
            return IRQ_MSI;
        end else begin
            return IRQ_MTI;
        end
    endfunction

endpackage

// File: rtl/csr_mtrap_unit_counter64.sv
// rtl/csr_mtrap_unit_counter64.sv - 64-bit event counter with half-word CSR write ports
module csr_mtrap_unit_counter64 #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_inc_en,
    input  logic            i_inhibit,
    input  logic            i_wr_lo,
    input  logic            i_wr_hi,
    input  logic [XLEN-1:0] i_wdata,
    output logic [63:0]     o_count
);

    logic [63:0] r_count;

    // A CSR write to either half suppresses the increment for that cycle; unwritten halves hold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_wr_lo || i_wr_hi) begin
            if (i_wr_lo) begin
                r_count[XLEN-1:0] <= i_wdata;
            end
            if (i_wr_hi) begin
                r_count[63:32] <= i_wdata[31:0];
            end
        end else if (i_inc_en && !i_inhibit) begin
            r_count <= r_count + 64'd1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/csr_mtrap_unit.sv
// rtl/csr_mtrap_unit.sv - machine-mode CSR file with interrupt/exception trap controller
module csr_mtrap_unit
    import csr_mtrap_unit_pkg::*;
#(
    parameter int              XLEN      = 64,
    parameter int              VECT_EN   = 1,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'('h8000_0000),
    parameter logic [XLEN-1:0] HART_ID   = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            csr_rden_i,
    input  logic            csr_wen_i,
    input  logic [1:0]      csr_op_i,
    input  logic [11:0]     csr_addr_i,
    input  logic [XLEN-1:0] csr_val_i,
    output logic [XLEN-1:0] csr_val_o,
    output logic            csr_ill_o,
    input  logic            ext_irq_i,
    input  logic            sft_irq_i,
    input  logic            tmr_irq_i,
    input  logic            exp_valid_i,
    input  logic [3:0]      exp_cause_i,
    input  logic [XLEN-1:0] exp_tval_i,
    input  logic [XLEN-1:0] exp_pc_i,
    output logic            irq_req_o,
    input  logic            irq_ack_i,
    input  logic [XLEN-1:0] irq_pc_i,
    input  logic            mret_ena_i,
    input  logic            instr_retire_i,
    output logic            trap_valid_o,
    output logic [XLEN-1:0] trap_pc_o,
    output logic [XLEN-1:0] mepc_o,
    output logic            glb_irq_o
);

    localparam logic [XLEN-1:0] MIE_MASK   = XLEN'(12'h888);
    localparam logic [XLEN-1:0] MTVEC_MASK = ~XLEN'((VECT_EN != 0) ? 2 : 3);
    localparam logic [XLEN-1:0] EPC_MASK   = ~XLEN'(1);

    logic            r_mstatus_mie;
    logic            r_mpie;
    logic [XLEN-1:0] r_mie;
    logic [XLEN-1:0] r_mtvec;
    logic [XLEN-1:0] r_mscratch;
    logic [XLEN-1:0] r_mepc;
    logic [XLEN-1:0] r_mcause;
    logic [XLEN-1:0] r_mtval;
    logic            r_cy_inh;
    logic            r_ir_inh;
    logic            r_trap_valid;
    logic [XLEN-1:0] r_trap_pc;
    trap_state_e     r_state;

    trap_state_e     w_next_state;
    logic [XLEN-1:0] w_mstatus;
    logic [XLEN-1:0] w_mip;
    logic [XLEN-1:0] w_rdata;
    logic            w_known;
    logic [XLEN-1:0] w_wdata;
    logic            w_wr_attempt;
    logic            w_ro_viol;
    logic            w_we;
    logic [2:0]      w_pend;
    logic            w_irq_cand;
    logic [3:0]      w_irq_code;
    logic            w_take_irq;
    logic            w_take_exc;
    logic            w_commit;
    logic [XLEN-1:0] w_trap_pc;
    logic [XLEN-1:0] w_cause;
    logic [63:0]     w_cycle;
    logic [63:0]     w_instret;

    // Assemble mstatus and mip views; MPP is hardwired to machine mode
    always_comb begin
        w_mstatus        = '0;
        w_mstatus[12:11] = 2'b11;
        w_mstatus[7]     = r_mpie;
        w_mstatus[3]     = r_mstatus_mie;
        w_mip            = '0;
        w_mip[11]        = ext_irq_i;
        w_mip[7]         = tmr_irq_i;
        w_mip[3]         = sft_irq_i;
    end

    // Read mux; also supplies the old value for set/clear operations
    always_comb begin
        w_rdata = '0;
        w_known = 1'b1;
        case (csr_addr_i)
            CSR_MSTATUS:       w_rdata = w_mstatus;
            CSR_MIE:           w_rdata = r_mie;
            CSR_MTVEC:         w_rdata = r_mtvec;
            CSR_MCOUNTINHIBIT: w_rdata = XLEN'({r_ir_inh, 1'b0, r_cy_inh});
            CSR_MSCRATCH:      w_rdata = r_mscratch;
            CSR_MEPC:          w_rdata = r_mepc;
            CSR_MCAUSE:        w_rdata = r_mcause;
            CSR_MTVAL:         w_rdata = r_mtval;
            CSR_MIP:           w_rdata = w_mip;
            CSR_MCYCLE:        w_rdata = w_cycle[XLEN-1:0];
            CSR_MINSTRET:      w_rdata = w_instret[XLEN-1:0];
            CSR_MCYCLEH: begin
                if (XLEN == 32) w_rdata = XLEN'(w_cycle[63:32]);
                else            w_known = 1'b0;
            end
            CSR_MINSTRETH: begin
                if (XLEN == 32) w_rdata = XLEN'(w_instret[63:32]);
                else            w_known = 1'b0;
            end
            CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: w_rdata = '0;
            CSR_MHARTID:       w_rdata = HART_ID;
            default:           w_known = 1'b0;
        endcase
    end

    // Write data and access legality; set/clear with zero operand never writes, so RO is fine
    always_comb begin
        case (csr_op_i)
            OP_WRITE: w_wdata = csr_val_i;
            OP_SET:   w_wdata = w_rdata | csr_val_i;
            OP_CLEAR: w_wdata = w_rdata & ~csr_val_i;
            default:  w_wdata = w_rdata;
        endcase
        w_wr_attempt = csr_wen_i && (csr_op_i != OP_NOP);
        w_ro_viol    = w_wr_attempt && (csr_addr_i[11:10] == 2'b11)
                       && ((csr_op_i == OP_WRITE) || (|csr_val_i));
        w_we         = w_wr_attempt && w_known && (csr_addr_i[11:10] != 2'b11);
    end

    assign csr_val_o = csr_rden_i ? w_rdata : '0;
    assign csr_ill_o = ((csr_rden_i || w_wr_attempt) && !w_known) || w_ro_viol;

    assign w_pend     = {w_mip[11] & r_mie[11], w_mip[3] & r_mie[3], w_mip[7] & r_mie[7]};
    assign w_irq_cand = r_mstatus_mie && (|w_pend);
    assign w_irq_code = irq_prio(w_pend);

    // FSM next state and trap selection; an exception preempts any pending acknowledge
    always_comb begin
        w_next_state = r_state;
        w_take_irq   = 1'b0;
        w_take_exc   = 1'b0;
        if (exp_valid_i) begin
            w_take_exc   = 1'b1;
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_irq_cand) w_next_state = ST_REQ;
                ST_REQ: begin
                    if (!w_irq_cand) begin
                        w_next_state = ST_IDLE;
                    end else if (irq_ack_i) begin
                        w_take_irq   = 1'b1;
                        w_next_state = ST_IDLE;
                    end
                end
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    // Trap target and cause; only interrupts use the vectored offset
    always_comb begin
        w_commit  = w_take_irq || w_take_exc;
        w_trap_pc = {r_mtvec[XLEN-1:2], 2'b00};
        if (w_take_irq && r_mtvec[0]) begin
            w_trap_pc = w_trap_pc + XLEN'({w_irq_code, 2'b00});
        end
        w_cause = '0;
        w_cause[XLEN-1] = w_take_irq;
        w_cause[3:0]    = w_take_exc ? exp_cause_i : w_irq_code;
    end

    assign irq_req_o    = (r_state == ST_REQ) && w_irq_cand;
    assign trap_valid_o = r_trap_valid;
    assign trap_pc_o    = r_trap_pc;
    assign mepc_o       = r_mepc;
    assign glb_irq_o    = r_mstatus_mie;

    // Trap FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    // mstatus: trap commit beats mret, mret beats a CSR write
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mstatus_mie <= 1'b0;
            r_mpie        <= 1'b0;
        end else if (w_commit) begin
            r_mpie        <= r_mstatus_mie;
            r_mstatus_mie <= 1'b0;
        end else if (mret_ena_i) begin
            r_mstatus_mie <= r_mpie;
            r_mpie        <= 1'b1;
        end else if (w_we && csr_addr_i == CSR_MSTATUS) begin
            r_mstatus_mie <= w_wdata[3];
            r_mpie        <= w_wdata[7];
        end
    end

    // Trap state registers: commit overrides same-cycle CSR writes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mepc   <= '0;
            r_mcause <= '0;
            r_mtval  <= '0;
        end else if (w_commit) begin
            r_mepc   <= (w_take_exc ? exp_pc_i : irq_pc_i) & EPC_MASK;
            r_mcause <= w_cause;
            r_mtval  <= w_take_exc ? exp_tval_i : '0;
        end else if (w_we) begin
            if (csr_addr_i == CSR_MEPC)   r_mepc   <= w_wdata & EPC_MASK;
            if (csr_addr_i == CSR_MCAUSE) r_mcause <= w_wdata;
            if (csr_addr_i == CSR_MTVAL)  r_mtval  <= w_wdata;
        end
    end

    // Plain read/write CSRs unaffected by traps
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mie      <= '0;
            r_mtvec    <= RESET_VEC & ~XLEN'(3);
            r_mscratch <= '0;
            r_cy_inh   <= 1'b0;
            r_ir_inh   <= 1'b0;
        end else if (w_we) begin
            if (csr_addr_i == CSR_MIE)      r_mie      <= w_wdata & MIE_MASK;
            if (csr_addr_i == CSR_MTVEC)    r_mtvec    <= w_wdata & MTVEC_MASK;
            if (csr_addr_i == CSR_MSCRATCH) r_mscratch <= w_wdata;
            if (csr_addr_i == CSR_MCOUNTINHIBIT) begin
                r_cy_inh <= w_wdata[0];
                r_ir_inh <= w_wdata[2];
            end
        end
    end

    // Redirect pulse to fetch, one cycle after commit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_trap_valid <= 1'b0;
            r_trap_pc    <= '0;
        end else begin
            r_trap_valid <= w_commit;
            if (w_commit) r_trap_pc <= w_trap_pc;
        end
    end

    csr_mtrap_unit_counter64 #(.XLEN(XLEN)) u_mcycle (
        .clk       (clk),
        .rst       (rst),
        .i_inc_en  (1'b1),
        .i_inhibit (r_cy_inh),
        .i_wr_lo   (w_we && csr_addr_i == CSR_MCYCLE),
        .i_wr_hi   (w_we && csr_addr_i == CSR_MCYCLEH),
        .i_wdata   (w_wdata),
        .o_count   (w_cycle)
    );

    csr_mtrap_unit_counter64 #(.XLEN(XLEN)) u_minstret (
        .clk       (clk),
        .rst       (rst),
        .i_inc_en  (instr_retire_i),
        .i_inhibit (r_ir_inh),
        .i_wr_lo   (w_we && csr_addr_i == CSR_MINSTRET),
        .i_wr_hi   (w_we && csr_addr_i == CSR_MINSTRETH),
        .i_wdata   (w_wdata),
        .o_count   (w_instret)
    );

endmodule
